// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the shared memory and the arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner_d;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, d_ack, rdata, mem_addr, mem_wr, mem_wdata, busy, owner_d
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, d_ack, rdata, mem_addr, mem_wr, mem_wdata, busy, owner_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and
// load/store; holds the access for MEM_LAT cycles and returns a one-cycle ack.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);
    localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    generate
        if (MEM_LAT < 1) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_grant_d;
    logic               r_owner_d;
    logic               r_busy;
    logic               r_if_ack;
    logic               r_d_ack;
    logic               r_mem_wr;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               w_any_req;
    logic               w_grant_d;
    logic               w_cnt_zero;

    // A tie is lost by whoever won last; a lone request always wins.
    always_comb begin
        w_any_req  = bus.if_req | bus.d_req;
        w_grant_d  = bus.d_req & (~bus.if_req | ~r_last_grant_d);
        w_cnt_zero = (r_cnt == {CNT_W{1'b0}});
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant latch, wait counter, read capture and ack generation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt          <= {CNT_W{1'b0}};
            r_last_grant_d <= 1'b1;
            r_owner_d      <= 1'b0;
            r_busy         <= 1'b0;
            r_if_ack       <= 1'b0;
            r_d_ack        <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mem_addr     <= {ADDR_W{1'b0}};
            r_mem_wdata    <= {DATA_W{1'b0}};
            r_rdata        <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_mem_addr  <= w_grant_d ? bus.d_addr : bus.if_addr;
                        r_mem_wdata <= w_grant_d ? bus.d_wdata : {DATA_W{1'b0}};
                        r_mem_wr    <= w_grant_d & bus.d_we;
                        r_owner_d   <= w_grant_d;
                        r_cnt       <= CNT_W'(MEM_LAT - 1);
                        r_busy      <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (w_cnt_zero) begin
                        // Stores leave the last read word untouched.
                        if (!r_mem_wr) begin
                            r_rdata <= bus.mem_rdata;
                        end
                        r_if_ack       <= ~r_owner_d;
                        r_d_ack        <= r_owner_d;
                        r_mem_wr       <= 1'b0;
                        r_last_grant_d <= r_owner_d;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.owner_d   = r_owner_d;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboarded accesses on a MEM_LAT=2 instance
// plus latency probes on MEM_LAT=1 and MEM_LAT=5 instances.
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus5 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(5)) dut5 (
        .clk(clk), .reset(reset), .bus(bus5)
    );

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.mem_rdata  = model_rd(bus.mem_addr);
    assign bus1.mem_rdata = model_rd(bus1.mem_addr);
    assign bus5.mem_rdata = model_rd(bus5.mem_addr);

    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic        model_last_d;
    logic [31:0] model_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the main instance: predict winner, push, wait for ack, pop and compare.
    task automatic do_access(input logic ireq, input logic [31:0] iaddr,
                             input logic dreq, input logic dwe,
                             input logic [31:0] daddr, input logic [31:0] dwdata,
                             input bit hold);
        exp_t e;
        exp_t got;
        int   n;
        int   wr_cycles;
        logic acked;
        bus.if_req  = ireq;
        bus.if_addr = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
        e.is_d  = dreq && (!ireq || !model_last_d);
        e.we    = e.is_d && dwe;
        e.addr  = e.is_d ? daddr : iaddr;
        e.wdata = e.is_d ? dwdata : 32'h0;
        if (!e.we) model_rdata = model_rd(e.addr);
        e.rdata = model_rdata;
        model_last_d = e.is_d;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        chk("busy_access", {31'd0, bus.busy}, 32'd1);
        chk("owner_d", {31'd0, bus.owner_d}, {31'd0, e.is_d});
        chk("mem_wr_start", {31'd0, bus.mem_wr}, {31'd0, e.we});
        if (!hold) begin
            bus.if_req  = 1'b0;
            bus.d_req   = 1'b0;
            bus.if_addr = ~iaddr;
            bus.d_addr  = daddr ^ 32'h0000_00C0;
            bus.d_wdata = ~dwdata;
            bus.d_we    = ~dwe;
        end
        n = 1;
        wr_cycles = 0;
        acked = 1'b0;
        while (!acked && n < 20) begin
            chk("mem_addr_held", bus.mem_addr, e.addr);
            chk("mem_wdata_held", bus.mem_wdata, e.wdata);
            if (bus.mem_wr) wr_cycles++;
            @(posedge clk);
            n++;
            @(negedge clk);
            acked = bus.if_ack | bus.d_ack;
        end
        chk("ack_seen", {31'd0, acked}, 32'd1);
        chk("ack_latency", n, LAT + 1);
        chk("ack_exclusive", {31'd0, bus.if_ack & bus.d_ack}, 32'd0);
        got = sb.pop_front();
        chk("ack_owner", {31'd0, bus.d_ack}, {31'd0, got.is_d});
        chk("rdata", bus.rdata, got.rdata);
        chk("mem_wr_done", {31'd0, bus.mem_wr}, 32'd0);
        chk("mem_wr_cycles", wr_cycles, got.we ? LAT : 0);
        @(posedge clk);
        @(negedge clk);
        chk("ack_pulse_end", {31'd0, bus.if_ack | bus.d_ack}, 32'd0);
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        time t0;
        time t1;
        int  n1;
        int  n5;
        reset = 1'b0;
        bus.if_req = 1'b0;  bus.if_addr = 32'h0;  bus.d_req = 1'b0;
        bus.d_we = 1'b0;    bus.d_addr = 32'h0;   bus.d_wdata = 32'h0;
        bus1.if_req = 1'b0; bus1.if_addr = 32'h0; bus1.d_req = 1'b0;
        bus1.d_we = 1'b0;   bus1.d_addr = 32'h0;  bus1.d_wdata = 32'h0;
        bus5.if_req = 1'b0; bus5.if_addr = 32'h0; bus5.d_req = 1'b0;
        bus5.d_we = 1'b0;   bus5.d_addr = 32'h0;  bus5.d_wdata = 32'h0;
        model_last_d = 1'b1;
        model_rdata  = 32'h0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_owner", {31'd0, bus.owner_d}, 32'd0);
        chk("rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Fetch from 0, store, load with mid-access input changes, another fetch.
        do_access(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_access(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0);
        do_access(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
        do_access(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Reset lands in the second ACCESS cycle of a store.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("abort_wr_before", {31'd0, bus.mem_wr}, 32'd1);
        bus.d_req = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        model_last_d = 1'b1;
        model_rdata  = 32'h0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort_no_ack_after", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        chk("abort_idle", {31'd0, bus.busy}, 32'd0);

        // Both requests held after reset: fetch, data, fetch at a 4-cycle pitch.
        t0 = $time;
        do_access(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1);
        t1 = $time;
        chk("rr_period", 32'(t1 - t0), 32'd40);
        do_access(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1);
        do_access(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        @(negedge clk);

        // Latency of the MEM_LAT=1 and MEM_LAT=5 builds.
        bus1.if_req = 1'b1; bus1.if_addr = 32'h44;
        bus5.if_req = 1'b1; bus5.if_addr = 32'h48;
        n1 = 0;
        n5 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                bus1.if_req = 1'b0;
                bus5.if_req = 1'b0;
            end
            if (bus1.if_ack && n1 == 0) n1 = k;
            if (bus5.if_ack && n5 == 0) n5 = k;
        end
        chk("lat1_edges", n1, 32'd2);
        chk("lat5_edges", n5, 32'd6);
        chk("lat1_rdata", bus1.rdata, model_rd(32'h44));
        chk("lat5_rdata", bus5.rdata, model_rd(32'h48));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
